fft_frame_capture: RTL and testbench
====================================

Name: fft_frame_capture

Overview:
- AXI4-Stream slave that sits on the trigger FFT master output channel.
- Receives complete 64-bin FFT frames and converts each bin to an approximate magnitude, |re|+|im|, saturated to MAG_W bits.
- Stores each frame in a ping-pong bin memory and tracks the peak bin per frame.
- Exposes the last committed frame through a registered random-read port so the trigger and readout logic can use it without stalling the FFT core.

Parameters:
- N_POINTS, 64: bins per frame; power of two.
- ADDR_W, 6: log2(N_POINTS).
- MAG_W, 10: stored magnitude width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- s_axis_tdata  in  32  [15:0] real, [31:16] imag, both signed two's complement
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accept
- s_axis_tlast  in  1  last bin of frame
- capture_enable  in  1  capture frames; sampled at the first beat of each frame
- frame_release  in  1  consumer finished with the read bank; single-cycle pulse
- rd_addr  in  ADDR_W  bin read address
- rd_data  out  MAG_W  magnitude of bin rd_addr; 1-cycle latency
- frame_valid  out  1  level; read bank holds a committed frame
- frame_done  out  1  1-cycle pulse on commit
- peak_bin  out  ADDR_W  index of max magnitude in the read bank
- peak_mag  out  MAG_W  max magnitude in the read bank
- frame_count  out  8  committed frames, wraps
- drop_count  out  8  frames dropped because the read bank was held; saturates at 255
- err_tlast_early  out  1  sticky; tlast seen before bin N_POINTS-1
- err_tlast_missing  out  1  sticky; no tlast on bin N_POINTS-1

Behaviour:
- Reset:
  - All outputs 0; s_axis_tready=0 during reset, 1 from the first cycle after reset deasserts.
  - State SOF, bin counter 0, write bank 0, read bank 1 marked empty.
- Handshake:
  - Beat accepted when tvalid & tready.
  - tready stays 1 outside reset; the block never back-pressures the FFT. Frames that cannot be stored are consumed and discarded.
- Magnitude:
  - abs(re)+abs(im) computed as 17-bit unsigned; abs(-32768)=32768.
  - mag = sum if sum < 2^MAG_W, else 2^MAG_W-1.
  - Written to the write bank at address = bin counter, on the accept cycle.
- State machine:
  - SOF: on an accepted beat, latch cap = capture_enable.
    - cap=1: write bin 0 and seed the running peak with (0, mag); go to CAPT, or stay in SOF and commit if tlast (N_POINTS=1 only). For N_POINTS>1, a beat with tlast in SOF sets err_tlast_early and discards the frame.
    - cap=0: go to DISC; no error flags set.
  - CAPT: each accepted beat increments the bin counter and writes the bin.
    - Running peak updates only if mag > current peak (strictly greater), so the lowest index wins ties.
    - tlast with counter < N_POINTS-1: set err_tlast_early, discard the partial frame, return to SOF.
    - Beat at counter N_POINTS-1 without tlast: set err_tlast_missing, go to DISC.
    - Beat at counter N_POINTS-1 with tlast: commit, return to SOF.
  - DISC: consume beats without writing; on an accepted tlast, return to SOF. The next beat is bin 0.
- Commit:
  - Takes effect on the same edge as the final beat.
  - If the read bank is empty, or frame_release is asserted in that cycle (release is applied first):
    - swap banks; frame_valid=1; frame_done pulses the next cycle;
    - peak_bin/peak_mag load the running peak;
    - frame_count increments.
  - Otherwise: drop the frame; the write bank is reused; drop_count increments (saturating); frame_valid and peak outputs are unchanged.
- frame_release:
  - With frame_valid=1 and no coincident commit: frame_valid=0 on the next cycle. Peak outputs hold until the next commit.
  - Ignored when frame_valid=0.
- Read port:
  - rd_data is registered from read-bank[rd_addr], with 1-cycle latency.
  - If frame_valid=0 when rd_addr is sampled, rd_data=0.
  - A bank swap on the same edge is not visible until the following read.
- Error flags: sticky until reset.
- Reset mid-frame: the partial frame is lost and all state returns to reset values. The first accepted beat after reset is bin 0, even if upstream is mid-frame; a resulting length mismatch is flagged per the rules above.

Optional Feature:
- Macro FFT_CAPTURE_PEAK_SKIP_DC_EN.
- Defined: bin 0 is stored but excluded from the peak search. The running peak seeds as (1, mag of bin 1) at bin 1, and ties resolve to the lowest index ≥1.
- Undefined: bin 0 participates in the peak search as described above.

Test Plan:
- Reset, then a 64-beat frame with bin k = (re=k, im=-k), tlast on beat 63, release held low:
  - frame_done pulses once; frame_valid=1; rd_addr=10 returns 20 one cycle later;
  - peak_bin=63, peak_mag=126; frame_count=1.
- Bin 5 = (re=-32768, im=-32768), all other bins 0:
  - rd_data at addr 5 = 1023; peak_bin=5, peak_mag=1023.
- Two frames back-to-back with no release:
  - second frame dropped, drop_count=1, rd_data still shows frame 1.
  - Repeat with frame_release pulsed on the final beat of frame 2: frame 2 committed, frame_count=2, drop_count unchanged.
- Framing errors:
  - tlast on beat 30: err_tlast_early=1, no frame_done; the next 64-beat frame commits normally.
  - Frame with no tlast at beat 63 followed by 10 beats ending in tlast: err_tlast_missing=1; the next frame commits normally.
- Enable and reset:
  - capture_enable=0 at the first beat, raised mid-frame: that frame is not captured; the following frame is captured.
  - Reset asserted at beat 40: all outputs 0; a full frame after reset commits with frame_count=1.
- Frame with bin 0 = 500, bin 7 = 300, all other bins 0:
  - macro undefined: peak_bin=0, peak_mag=500;
  - macro defined: peak_bin=7, peak_mag=300.

Source files
------------

// File: rtl/fft_frame_capture.sv
`default_nettype none
// ============================================================================
// Module  : fft_frame_capture
// Brief   : AXI4-Stream FFT frame capture into ping-pong |re|+|im| bin memory
//           with per-frame peak tracking. Option: FFT_CAPTURE_PEAK_SKIP_DC_EN.
// Revision: 1.0 - initial release
// ============================================================================
module fft_frame_capture #(
    parameter int N_POINTS = 64,
    parameter int ADDR_W   = 6,
    parameter int MAG_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              capture_enable,
    input  logic              frame_release,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [MAG_W-1:0]  rd_data,
    output logic              frame_valid,
    output logic              frame_done,
    output logic [ADDR_W-1:0] peak_bin,
    output logic [MAG_W-1:0]  peak_mag,
    output logic [7:0]        frame_count,
    output logic [7:0]        drop_count,
    output logic              err_tlast_early,
    output logic              err_tlast_missing
);

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N_POINTS - 1);
    localparam logic [ADDR_W-1:0] BIN_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {S_SOF = 2'd0, S_CAPT = 2'd1, S_DISC = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   bin_q, bin_d;
    logic                wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0]   run_bin_q, run_bin_d;
    logic [MAG_W-1:0]    run_mag_q, run_mag_d;
    logic                frame_valid_q, frame_valid_d;
    logic                frame_done_q, frame_done_d;
    logic [ADDR_W-1:0]   peak_bin_q, peak_bin_d;
    logic [MAG_W-1:0]    peak_mag_q, peak_mag_d;
    logic [7:0]          frame_count_q, frame_count_d;
    logic [7:0]          drop_count_q, drop_count_d;
    logic                err_early_q, err_early_d;
    logic                err_missing_q, err_missing_d;
    logic                tready_q;
    logic [MAG_W-1:0]    rd_data_q, rd_data_d;

    logic [MAG_W-1:0]    bank_mem [2*N_POINTS];

    logic                accept;
    logic [16:0]         re_x, im_x, re_abs, im_abs, mag_sum;
    logic [MAG_W-1:0]    mag;
    logic [ADDR_W-1:0]   nxt_bin;
    logic [MAG_W-1:0]    nxt_mag;
    logic                mem_we;
    logic                commit;

    assign s_axis_tready = tready_q & ~reset;
    assign accept        = s_axis_tvalid & s_axis_tready;

    // Sign-extend to 17 bits so abs(-32768) = 32768 is representable.
    assign re_x    = {s_axis_tdata[15], s_axis_tdata[15:0]};
    assign im_x    = {s_axis_tdata[31], s_axis_tdata[31:16]};
    assign re_abs  = re_x[16] ? (~re_x + 17'd1) : re_x;
    assign im_abs  = im_x[16] ? (~im_x + 17'd1) : im_x;
    assign mag_sum = re_abs + im_abs;
    assign mag     = (|mag_sum[16:MAG_W]) ? {MAG_W{1'b1}} : mag_sum[MAG_W-1:0];

    always_comb begin
        // Running peak including the current beat; strict '>' keeps the lowest index on ties.
        if (state_q == S_SOF) begin
            nxt_bin = '0;
            nxt_mag = mag;
`ifdef FFT_CAPTURE_PEAK_SKIP_DC_EN
        end else if (bin_q == BIN_ONE) begin
            nxt_bin = BIN_ONE;
            nxt_mag = mag;
`endif
        end else if (mag > run_mag_q) begin
            nxt_bin = bin_q;
            nxt_mag = mag;
        end else begin
            nxt_bin = run_bin_q;
            nxt_mag = run_mag_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        bin_d         = bin_q;
        wr_bank_d     = wr_bank_q;
        run_bin_d     = run_bin_q;
        run_mag_d     = run_mag_q;
        frame_valid_d = frame_valid_q;
        frame_done_d  = 1'b0;
        peak_bin_d    = peak_bin_q;
        peak_mag_d    = peak_mag_q;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;
        err_early_d   = err_early_q;
        err_missing_d = err_missing_q;
        mem_we        = 1'b0;
        commit        = 1'b0;

        if (frame_release && frame_valid_q) begin
            frame_valid_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                S_SOF: begin
                    bin_d = '0;
                    if (capture_enable) begin
                        mem_we    = 1'b1;
                        run_bin_d = nxt_bin;
                        run_mag_d = nxt_mag;
                        if (s_axis_tlast) begin
                            if (N_POINTS == 1) commit = 1'b1;
                            else err_early_d = 1'b1;
                        end else begin
                            state_d = S_CAPT;
                            bin_d   = BIN_ONE;
                        end
                    end else if (!s_axis_tlast) begin
                        state_d = S_DISC;
                    end
                end
                S_CAPT: begin
                    mem_we    = 1'b1;
                    run_bin_d = nxt_bin;
                    run_mag_d = nxt_mag;
                    if (bin_q == LAST_BIN) begin
                        bin_d = '0;
                        if (s_axis_tlast) begin
                            commit  = 1'b1;
                            state_d = S_SOF;
                        end else begin
                            err_missing_d = 1'b1;
                            state_d       = S_DISC;
                        end
                    end else if (s_axis_tlast) begin
                        err_early_d = 1'b1;
                        state_d     = S_SOF;
                        bin_d       = '0;
                    end else begin
                        bin_d = bin_q + BIN_ONE;
                    end
                end
                S_DISC: begin
                    if (s_axis_tlast) begin
                        state_d = S_SOF;
                        bin_d   = '0;
                    end
                end
                default: state_d = S_SOF;
            endcase
        end

        if (commit) begin
            if (!frame_valid_q || frame_release) begin
                wr_bank_d     = ~wr_bank_q;
                frame_valid_d = 1'b1;
                frame_done_d  = 1'b1;
                peak_bin_d    = nxt_bin;
                peak_mag_d    = nxt_mag;
                frame_count_d = frame_count_q + 8'd1;
            end else if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end

        // Bank select uses the pre-swap bank, so a same-edge swap shows up one read later.
        rd_data_d = frame_valid_q ? bank_mem[{~wr_bank_q, rd_addr}] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_SOF;
            bin_q         <= '0;
            wr_bank_q     <= 1'b0;
            run_bin_q     <= '0;
            run_mag_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            peak_bin_q    <= '0;
            peak_mag_q    <= '0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
            tready_q      <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            bin_q         <= bin_d;
            wr_bank_q     <= wr_bank_d;
            run_bin_q     <= run_bin_d;
            run_mag_q     <= run_mag_d;
            frame_valid_q <= frame_valid_d;
            frame_done_q  <= frame_done_d;
            peak_bin_q    <= peak_bin_d;
            peak_mag_q    <= peak_mag_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
            err_early_q   <= err_early_d;
            err_missing_q <= err_missing_d;
            tready_q      <= 1'b1;
            rd_data_q     <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            bank_mem[{wr_bank_q, bin_q}] <= mag;
        end
    end

    assign rd_data           = rd_data_q;
    assign frame_valid       = frame_valid_q;
    assign frame_done        = frame_done_q;
    assign peak_bin          = peak_bin_q;
    assign peak_mag          = peak_mag_q;
    assign frame_count       = frame_count_q;
    assign drop_count        = drop_count_q;
    assign err_tlast_early   = err_early_q;
    assign err_tlast_missing = err_missing_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_fft_frame_capture
// Brief   : Self-checking bench for fft_frame_capture (table, directed, random).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fft_frame_capture;

    localparam int N   = 64;
    localparam int AW  = 6;
    localparam int MW  = 10;
    localparam int MAX = (1 << MW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic          capture_enable;
    logic          frame_release;
    logic [AW-1:0] rd_addr;
    logic [MW-1:0] rd_data;
    logic          frame_valid;
    logic          frame_done;
    logic [AW-1:0] peak_bin;
    logic [MW-1:0] peak_mag;
    logic [7:0]    frame_count;
    logic [7:0]    drop_count;
    logic          err_tlast_early;
    logic          err_tlast_missing;

    always #5 clk = ~clk;

    fft_frame_capture #(.N_POINTS(N), .ADDR_W(AW), .MAG_W(MW)) dut (
        .clk              (clk),
        .reset            (reset),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tlast     (s_axis_tlast),
        .capture_enable   (capture_enable),
        .frame_release    (frame_release),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .frame_valid      (frame_valid),
        .frame_done       (frame_done),
        .peak_bin         (peak_bin),
        .peak_mag         (peak_mag),
        .frame_count      (frame_count),
        .drop_count       (drop_count),
        .err_tlast_early  (err_tlast_early),
        .err_tlast_missing(err_tlast_missing)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    always @(posedge clk) if (frame_done === 1'b1) done_cnt++;

    // Reference state: what the consumer should see, tracked per whole frame.
    int frame_re [N];
    int frame_im [N];
    int m_bank   [N];
    bit m_valid;
    int m_count, m_drop, m_pbin, m_pmag, m_commits;

    typedef struct { int re; int im; int mag; } vec_t;
    vec_t tbl [12];

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_mag(input int re, input int im);
        int s;
        s = (re < 0 ? -re : re) + (im < 0 ? -im : im);
        return (s > MAX) ? MAX : s;
    endfunction

    task automatic read_bin(input int a, output int v);
        rd_addr = a[AW-1:0];
        tick();
        v = int'(rd_data);
    endtask

    task automatic beat(input int re, input int im, input bit last, input bit cen, input bit rel);
        s_axis_tvalid  = 1'b1;
        s_axis_tdata   = {im[15:0], re[15:0]};
        s_axis_tlast   = last;
        capture_enable = cen;
        frame_release  = rel;
        tick();
        s_axis_tvalid  = 1'b0;
        s_axis_tlast   = 1'b0;
        frame_release  = 1'b0;
    endtask

    task automatic model_reset();
        m_valid = 0; m_count = 0; m_drop = 0; m_pbin = 0; m_pmag = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_axis_tvalid = 1'b0; frame_release = 1'b0; s_axis_tlast = 1'b0;
        tick(); tick();
        check("rst_tready", s_axis_tready, 0);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_peak_bin", peak_bin, 0);
        check("rst_peak_mag", peak_mag, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_err_early", err_tlast_early, 0);
        check("rst_err_missing", err_tlast_missing, 0);
        reset = 1'b0;
        tick();
        check("post_rst_tready", s_axis_tready, 1);
        model_reset();
    endtask

    // Sends a well-formed frame from frame_re/frame_im and updates the reference.
    task automatic send_frame(input bit cen, input int rel_at, input bit gaps);
        int mags [N];
        int start, pb, pm;
        for (int k = 0; k < N; k++) begin
            if (gaps) while ($urandom_range(0, 3) == 0) tick();
            beat(frame_re[k], frame_im[k], k == N - 1, (k == 0) ? cen : 1'b1, k == rel_at);
        end
        if (rel_at >= 0 && rel_at < N - 1) m_valid = 0;
        if (cen) begin
            for (int k = 0; k < N; k++) mags[k] = ref_mag(frame_re[k], frame_im[k]);
`ifdef FFT_CAPTURE_PEAK_SKIP_DC_EN
            start = 1;
`else
            start = 0;
`endif
            pb = start; pm = mags[start];
            for (int k = start + 1; k < N; k++) if (mags[k] > pm) begin pb = k; pm = mags[k]; end
            if (!m_valid || rel_at == N - 1) begin
                m_bank = mags; m_pbin = pb; m_pmag = pm;
                m_valid = 1; m_count = (m_count + 1) % 256; m_commits++;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end else if (rel_at == N - 1) begin
            m_valid = 0;
        end
    endtask

    task automatic check_model(input string tag);
        int v, a;
        tick();
        check({tag, "_done_pulses"}, done_cnt, m_commits);
        check({tag, "_frame_valid"}, frame_valid, m_valid);
        check({tag, "_frame_count"}, frame_count, m_count);
        check({tag, "_drop_count"}, drop_count, m_drop);
        check({tag, "_peak_bin"}, peak_bin, m_pbin);
        check({tag, "_peak_mag"}, peak_mag, m_pmag);
        if (m_valid) begin
            for (int i = 0; i < 4; i++) begin
                a = $urandom_range(0, N - 1);
                read_bin(a, v);
                check({tag, "_rd_data"}, v, m_bank[a]);
            end
        end else begin
            read_bin($urandom_range(0, N - 1), v);
            check({tag, "_rd_empty"}, v, 0);
        end
    endtask

    task automatic fill_random();
        int mode;
        mode = $urandom_range(0, 2);
        for (int k = 0; k < N; k++) begin
            case (mode)
                0: begin frame_re[k] = $urandom_range(0, 7) - 4; frame_im[k] = $urandom_range(0, 7) - 4; end
                1: begin frame_re[k] = $urandom_range(0, 65535) - 32768; frame_im[k] = $urandom_range(0, 65535) - 32768; end
                default: begin frame_re[k] = $urandom_range(0, 1200) - 600; frame_im[k] = $urandom_range(0, 1200) - 600; end
            endcase
        end
    endtask

    task automatic fill_zero();
        for (int k = 0; k < N; k++) begin frame_re[k] = 0; frame_im[k] = 0; end
    endtask

    initial begin
        int v, base, r, rel;
        bit cen;
        reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        capture_enable = 1'b0; frame_release = 1'b0; rd_addr = '0;
        m_commits = 0;
        do_reset();

        // Ramp frame: bin k = (k, -k).
        for (int k = 0; k < N; k++) begin frame_re[k] = k; frame_im[k] = -k; end
        base = done_cnt;
        send_frame(1'b1, -1, 1'b0);
        check("t1_done_high", frame_done, 1);
        check("t1_valid", frame_valid, 1);
        tick();
        check("t1_done_low", frame_done, 0);
        check("t1_done_once", done_cnt - base, 1);
        read_bin(10, v);
        check("t1_rd10", v, 20);
        check("t1_peak_bin", peak_bin, 63);
        check("t1_peak_mag", peak_mag, 126);
        check("t1_count", frame_count, 1);
        check_model("t1");

        // Magnitude table, released on the final beat so it commits.
        tbl[0]  = '{3, -4, 7};          tbl[1]  = '{0, 0, 0};
        tbl[2]  = '{-1, -1, 2};         tbl[3]  = '{300, -200, 500};
        tbl[4]  = '{-511, -511, 1022};  tbl[5]  = '{-32768, -32768, 1023};
        tbl[6]  = '{1023, 0, 1023};     tbl[7]  = '{1024, 0, 1023};
        tbl[8]  = '{512, 511, 1023};    tbl[9]  = '{32767, 32767, 1023};
        tbl[10] = '{-32768, 0, 1023};   tbl[11] = '{-512, -511, 1023};
        fill_zero();
        for (int i = 0; i < 12; i++) begin frame_re[i] = tbl[i].re; frame_im[i] = tbl[i].im; end
        send_frame(1'b1, N - 1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            read_bin(i, v);
            check($sformatf("tbl_mag_%0d", i), v, tbl[i].mag);
        end
        check("tbl_peak_bin", peak_bin, 5);
        check("tbl_peak_mag", peak_mag, 1023);
        check_model("tbl");

        // Commit, then a dropped frame, then a frame released on its last beat.
        fill_random(); send_frame(1'b1, N - 1, 1'b0); check_model("b2b_a");
        fill_random(); send_frame(1'b1, -1, 1'b0);
        check("b2b_drop", drop_count, 1);
        check_model("b2b_b");
        fill_random(); send_frame(1'b1, N - 1, 1'b0); check_model("b2b_c");

        // Early tlast on beat 30.
        base = done_cnt;
        for (int k = 0; k <= 30; k++) beat(k, 0, k == 30, 1'b1, 1'b0);
        tick();
        check("early_flag", err_tlast_early, 1);
        check("early_missing_clear", err_tlast_missing, 0);
        check("early_no_done", done_cnt - base, 0);
        check_model("early");
        fill_random(); send_frame(1'b1, N - 1, 1'b1); check_model("early_next");

        // Missing tlast: 64 beats without it, then 10 more ending in tlast.
        for (int k = 0; k < N + 10; k++) beat(k, 1, k == N + 9, 1'b1, 1'b0);
        tick();
        check("missing_flag", err_tlast_missing, 1);
        check_model("missing");
        fill_random(); send_frame(1'b1, N - 1, 1'b0); check_model("missing_next");

        // capture_enable low on the first beat only.
        fill_random(); send_frame(1'b0, -1, 1'b0); check_model("cen0");
        fill_random(); send_frame(1'b1, N - 1, 1'b0); check_model("cen1");

        // Reset in the middle of a frame.
        for (int k = 0; k < 40; k++) beat(k, k, 1'b0, 1'b1, 1'b0);
        do_reset();
        fill_random(); send_frame(1'b1, -1, 1'b0);
        check("rst_mid_count", frame_count, 1);
        check_model("rst_mid");

        // Randomized frames, enables, releases and stream gaps.
        for (int it = 0; it < 10; it++) begin
            fill_random();
            cen = ($urandom_range(0, 4) != 0);
            r = $urandom_range(0, 2);
            rel = (r == 0) ? -1 : (r == 1) ? N - 1 : int'($urandom_range(0, N - 2));
            send_frame(cen, rel, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                frame_release = 1'b1; tick(); frame_release = 1'b0;
                m_valid = 0;
            end
            check_model($sformatf("rnd%0d", it));
        end

        // DC-bin peak handling.
        fill_zero();
        frame_re[0] = 500; frame_re[7] = 300;
        send_frame(1'b1, N - 1, 1'b0);
        tick();
`ifdef FFT_CAPTURE_PEAK_SKIP_DC_EN
        check("dc_peak_bin", peak_bin, 7);
        check("dc_peak_mag", peak_mag, 300);
`else
        check("dc_peak_bin", peak_bin, 0);
        check("dc_peak_mag", peak_mag, 500);
`endif
        read_bin(0, v);
        check("dc_bin0_stored", v, 500);
        check_model("dc");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
